// File: rtl/alu_pkg.sv
// Opcodes and multiply/divide sequencer states shared by the ALU, the
// mul/div unit and the control sequencer.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_addsub33.sv
// 33-bit adder/subtractor: y = a + b, or a - b when sub is set.
module addsub33 #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] y_o
);

  assign y_o = a_i + (b_i ^ {N{sub_i}}) + {{(N-1){1'b0}}, sub_i};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring on
// magnitudes), one bit per clock, two-cycle FIX phase, one-cycle done strobe.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fix_ph_q, fix_ph_d;
  logic             is_div_q, is_div_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_a, add_b, sum;
  logic             add_sub;
  logic             accept;

  assign accept = start && is_muldiv(opcode) &&
                  ((state_q == MD_IDLE) || (state_q == MD_DONE));

  addsub33 #(.N(WIDTH + 1)) u_addsub (
    .a_i   (add_a),
    .b_i   (add_b),
    .sub_i (add_sub),
    .y_o   (sum)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == '0) state_d = MD_FIX;
      MD_FIX:  if (fix_ph_q) state_d = MD_DONE;
      MD_DONE: state_d = accept ? MD_RUN : MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == MD_RUN) || (state_q == MD_FIX);
    done = (state_q == MD_DONE);
  end

  // Single adder operand steering: Booth step, non-restoring step,
  // remainder restore (FIX phase 0), remainder negation (FIX phase 1).
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == MD_RUN) begin
      if (is_div_q) begin
        add_a   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        add_b   = {1'b0, m_q};
        add_sub = ~p_q[WIDTH];
      end else begin
        add_a = p_q;
        unique case ({q_q[0], qm1_q})
          2'b01:   add_b = {m_q[WIDTH-1], m_q};
          2'b10: begin
            add_b   = {m_q[WIDTH-1], m_q};
            add_sub = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
    end else if (state_q == MD_FIX) begin
      if (!fix_ph_q) begin
        add_a = p_q;
        add_b = {1'b0, m_q};
      end else begin
        add_b   = {1'b0, p_q[WIDTH-1:0]};
        add_sub = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    fix_ph_d = fix_ph_q;
    is_div_d = is_div_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    p_d      = p_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    if (accept) begin
      is_div_d = (opcode == OP_DIV);
      sb_d     = B[WIDTH-1];
      dz_d     = (B == '0);
      a_d      = A;
      cnt_d    = CW'(WIDTH - 1);
      fix_ph_d = 1'b0;
      p_d      = '0;
      qm1_d    = 1'b0;
      if (opcode == OP_DIV) begin
        m_d = B[WIDTH-1] ? -B : B;
        q_d = A[WIDTH-1] ? -A : A;
      end else begin
        m_d = A;
        q_d = B;
      end
    end else begin
      unique case (state_q)
        MD_RUN: begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) begin
            p_d = sum;
            q_d = {q_q[WIDTH-2:0], ~sum[WIDTH]};
          end else begin
            p_d   = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
          end
        end
        MD_FIX: begin
          if (!fix_ph_q) begin
            fix_ph_d = 1'b1;
            if (is_div_q && p_q[WIDTH]) p_d = sum;
          end else if (!is_div_q) begin
            hi_d  = p_q[WIDTH-1:0];
            lo_d  = q_q;
            dbz_d = 1'b0;
          end else if (dz_q) begin
            hi_d  = a_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            // Truncating division: remainder follows A, quotient sign is sign(A)^sign(B).
            hi_d  = a_q[WIDTH-1] ? sum[WIDTH-1:0] : p_q[WIDTH-1:0];
            lo_d  = (a_q[WIDTH-1] ^ sb_q) ? -q_q : q_q;
            dbz_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q    <= '0;
      fix_ph_q <= 1'b0;
      is_div_q <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      p_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      fix_ph_q <= fix_ph_d;
      is_div_q <= is_div_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      p_q      <= p_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
